// File: rtl/des_f_serial.sv
// Serial DES round function f(R,K): E expansion and key mix, one shared S-box
// walked through ids 1..8 on successive cycles, then the P permutation.

module Sbox (
  input  logic [5:0] in,
  input  logic [3:0] id,
  output logic [3:0] out
);
  // Each table holds 64 nibbles, entry 0 in the top nibble, indexed row*16+col.
  localparam logic [255:0] S1 = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
  localparam logic [255:0] S2 = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
  localparam logic [255:0] S3 = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
  localparam logic [255:0] S4 = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
  localparam logic [255:0] S5 = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
  localparam logic [255:0] S6 = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
  localparam logic [255:0] S7 = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
  localparam logic [255:0] S8 = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

  logic [255:0] tbl, sh;
  logic [5:0]   idx;

  always_comb begin
    tbl = '0;
    unique case (id)
      4'd1: tbl = S1;
      4'd2: tbl = S2;
      4'd3: tbl = S3;
      4'd4: tbl = S4;
      4'd5: tbl = S5;
      4'd6: tbl = S6;
      4'd7: tbl = S7;
      4'd8: tbl = S8;
    endcase
  end

  // Row comes from the outer bits, column from the inner four.
  assign idx = {in[5], in[0], in[4:1]};
  assign sh  = tbl << {idx, 2'b00};
  assign out = sh[255:252];
endmodule

module des_f_serial (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] r_in,
  input  logic [47:0] subkey,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] f_out
);
  localparam logic [1:0] IDLE = 2'd0, SBOX = 2'd1, DONE = 2'd2;

  logic [1:0]  state;
  logic [2:0]  k;
  logic [47:0] x;
  logic [31:0] s, s_next;
  logic [5:0]  sb_in;
  logic [3:0]  sb_id, sb_out;

  // Chunk j of E takes DES bits 4j..4j+5, wrapping 0->32 and 33->1.
  function automatic logic [47:0] e_exp(input logic [31:0] r);
    int src;
    e_exp = '0;
    for (int j = 0; j < 8; j++)
      for (int m = 0; m < 6; m++) begin
        src = 4*j + m;
        if (src == 0) src = 32;
        else if (src == 33) src = 1;
        e_exp[47-(6*j+m)] = r[32-src];
      end
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] v);
    p_perm = {v[16], v[25], v[12], v[11], v[3],  v[20], v[4],  v[15],
              v[31], v[17], v[9],  v[6],  v[27], v[14], v[1],  v[22],
              v[30], v[24], v[8],  v[18], v[0],  v[5],  v[29], v[23],
              v[13], v[19], v[2],  v[26], v[10], v[21], v[28], v[7]};
  endfunction

  always_comb begin
    sb_in  = x[47:42];
    s_next = s;
    for (int i = 0; i < 8; i++)
      if (k == 3'(i)) begin
        sb_in                = x[47-6*i -: 6];
        s_next[31-4*i -: 4]  = sb_out;
      end
  end

  // Id parks at 1 outside SBOX so the S-box never sees an unmapped id.
  assign sb_id     = (state == SBOX) ? ({1'b0, k} + 4'd1) : 4'd1;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  Sbox u_sbox (.in(sb_in), .id(sb_id), .out(sb_out));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k     <= '0;
      x     <= '0;
      s     <= '0;
      f_out <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          x     <= e_exp(r_in) ^ subkey;
          s     <= '0;
          k     <= '0;
          state <= SBOX;
        end
        SBOX: begin
          s <= s_next;
          k <= k + 3'd1;
          if (k == 3'd7) begin
            f_out <= p_perm(s_next);
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_des_f_serial.sv
// Scoreboard bench for des_f_serial: expected f values from a table-driven
// model are queued at acceptance and popped when a result is handed out.

module tb_des_f_serial;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] r_in = '0;
  logic [47:0] subkey = '0;
  logic        in_ready, out_valid;
  logic [31:0] f_out;
  logic [31:0] last_f;

  int checks = 0, errors = 0;
  logic [31:0] exp_q[$];

  des_f_serial dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .r_in(r_in), .subkey(subkey), .out_valid(out_valid), .out_ready(out_ready),
    .f_out(f_out)
  );

  always #5 clk = ~clk;

  int E_T[48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                  16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  int P_T[32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                  2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  logic [255:0] SB[8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [47:0] model_x(input logic [31:0] r, input logic [47:0] kk);
    logic [47:0] e;
    for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
    return e ^ kk;
  endfunction

  function automatic logic [31:0] model_s(input logic [47:0] xx);
    logic [31:0] sv;
    logic [5:0]  six;
    int          idx;
    for (int b = 0; b < 8; b++) begin
      six = xx[47-6*b -: 6];
      idx = 32*int'(six[5]) + 16*int'(six[0]) + int'(six[4:1]);
      sv[31-4*b -: 4] = SB[b][255-4*idx -: 4];
    end
    return sv;
  endfunction

  function automatic logic [31:0] model_f(input logic [31:0] r, input logic [47:0] kk);
    logic [31:0] sv, p;
    sv = model_s(model_x(r, kk));
    for (int i = 0; i < 32; i++) p[31-i] = sv[32-P_T[i]];
    return p;
  endfunction

  // Shared S-box id must stay in 1..8 and track k+1 while stepping.
  always @(negedge clk) if (rst_n === 1'b1) begin
    checks++;
    if (dut.sb_id < 4'd1 || dut.sb_id > 4'd8 ||
        (dut.state == 2'd1 && dut.sb_id !== ({1'b0, dut.k} + 4'd1))) begin
      errors++;
      $display("FAIL sbox_id got %0d want %0d (state %0d)", dut.sb_id, dut.k + 3'd1, dut.state);
    end
  end

  task automatic send(input logic [31:0] r, input logic [47:0] kk, input bit push);
    @(negedge clk);
    in_valid = 1'b1; r_in = r; subkey = kk;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL send_in_ready got %b want 1", in_ready); end
    if (push) exp_q.push_back(model_f(r, kk));
    @(posedge clk); #1;
    in_valid = 1'b0; r_in = $urandom; subkey = {16'($urandom), $urandom};
  endtask

  task automatic collect(input string name, input int hold);
    int n;
    logic [31:0] want;
    out_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL %s_timeout got out_valid %b want 1", name, out_valid); return;
    end
    last_f = f_out;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || f_out !== last_f) begin
        errors++; $display("FAIL %s_hold got %b/%h want 1/%h", name, out_valid, f_out, last_f);
      end
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL %s_unexpected got %h want no result", name, f_out);
    end else begin
      want = exp_q.pop_front();
      if (f_out !== want) begin errors++; $display("FAIL %s_f got %h want %h", name, f_out, want); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL %s_release got in_ready %b out_valid %b want 1 0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || f_out !== 32'h0) begin
      errors++; $display("FAIL reset_state got %b %b %h want 0 1 00000000", out_valid, in_ready, f_out);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_zero();
    send(32'h0, 48'h0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== (i == 8)) begin
        errors++; $display("FAIL zero_latency edge %0d got %b want %b", i, out_valid, i == 8);
      end
    end
    checks++;
    if (dut.s !== 32'hEFA72C4D) begin errors++; $display("FAIL zero_s got %h want EFA72C4D", dut.s); end
    collect("zero", 0);
    checks++;
    if (last_f !== 32'hD8D8DBBC) begin errors++; $display("FAIL zero_const got %h want D8D8DBBC", last_f); end
  endtask

  task automatic test_standard();
    send(32'hF0AAF0AA, 48'h1B02EFFC7072, 1'b1);
    checks++;
    if (dut.x !== 48'h6117BA866527) begin errors++; $display("FAIL std_x got %h want 6117BA866527", dut.x); end
    collect("std", 0);
    checks++;
    if (dut.s !== 32'h5C82B597) begin errors++; $display("FAIL std_s got %h want 5C82B597", dut.s); end
    checks++;
    if (last_f !== 32'h234AA9BB) begin errors++; $display("FAIL std_const got %h want 234AA9BB", last_f); end
  endtask

  task automatic test_backpressure();
    send(32'hF0AAF0AA, 48'h1B02EFFC7072, 1'b1);
    collect("bp", 15);
    checks++;
    if (last_f !== 32'h234AA9BB) begin errors++; $display("FAIL bp_const got %h want 234AA9BB", last_f); end
  endtask

  task automatic test_busy_input();
    send(32'h12345678, 48'hA5A5_0F0F_3C3C, 1'b1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom); r_in = $urandom; subkey = {16'($urandom), $urandom};
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL busy_in_ready cycle %0d got %b want 0", i, in_ready); end
    end
    @(negedge clk); in_valid = 1'b0;
    collect("busy", 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic [47:0] kk;
    for (int v = 0; v < 6; v++) begin
      r = $urandom; kk = {16'($urandom), $urandom};
      send(r, kk, 1'b1);
      collect("rand", int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_mid();
    send(32'hDEADBEEF, 48'h0123_4567_89AB, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (dut.k !== 3'd3) begin errors++; $display("FAIL mid_k got %0d want 3", dut.k); end
    rst_n = 1'b0; #1;
    checks++;
    if (out_valid !== 1'b0 || f_out !== 32'h0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset got %b %h %b want 0 00000000 1", out_valid, f_out, in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale cycle %0d got %b want 0", i, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_standard();
    test_backpressure();
    test_busy_input();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
